// File: rtl/proc_scheduler_if.sv
// Bundled BIOS load channel, CPU context-switch handshake and run-status signals
// for the round-robin process scheduler.
interface proc_scheduler_if #(
  parameter int NPROC = 8
);
  localparam int PW = $clog2(NPROC);

  logic          enable;
  logic          load_valid;
  logic [31:0]   load_page;
  logic          load_ready;
  logic          load_err;
  logic          switch_req;
  logic          switch_ack;
  logic [31:0]   next_pc;
  logic [15:0]   page_base;
  logic [15:0]   page_limit;
  logic [PW-1:0] cur_pid;
  logic          running;
  logic          idle;
  logic [31:0]   pc_save;
  logic          yield_req;
  logic          proc_exit;

  // master: the scheduler itself; slave: the BIOS/CPU side driving it
  modport master (
    input  enable, load_valid, load_page, switch_ack, pc_save, yield_req, proc_exit,
    output load_ready, load_err, switch_req, next_pc, page_base, page_limit,
           cur_pid, running, idle
  );

  modport slave (
    output enable, load_valid, load_page, switch_ack, pc_save, yield_req, proc_exit,
    input  load_ready, load_err, switch_req, next_pc, page_base, page_limit,
           cur_pid, running, idle
  );
endinterface

// File: rtl/proc_scheduler.sv
// Round-robin process scheduler: holds the loaded page table and time-slices
// programs onto the CPU through a request/acknowledge context switch.
//
// state    | meaning
// ---------+------------------------------------------------------------
// WAIT     | BIOS still in control, nothing dispatched
// SELECT   | round-robin search for the next valid slot (idle if none)
// DISPATCH | switch_req high, waiting for the CPU to take the context
// RUN      | program executing, quantum counter running down
// SAVE     | capture the CPU PC into the running slot
module proc_scheduler #(
  parameter int NPROC   = 8,
  parameter int QUANTUM = 64
) (
  input  logic              clk,
  input  logic              reset,
  proc_scheduler_if.master  bus
);
  localparam int PW = $clog2(NPROC);
  localparam int QW = $clog2(QUANTUM);

  localparam logic [2:0] S_WAIT     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_DISPATCH = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_SAVE     = 3'd4;

  logic [2:0]       state;
  logic [NPROC-1:0] valid;
  logic [15:0]      base_q  [NPROC];
  logic [15:0]      limit_q [NPROC];
  logic [31:0]      pc_q    [NPROC];
  logic [QW-1:0]    qcnt;

  logic [PW-1:0]    free_idx;
  logic [PW-1:0]    sel_idx;
  logic [PW-1:0]    cand;
  logic             sel_found;
  logic             load_fire;
  logic             load_bad;

  assign bus.load_ready = ~&valid;
  assign load_fire      = bus.load_valid && bus.load_ready;
  assign load_bad       = bus.load_page[31:16] > bus.load_page[15:0];
  assign bus.switch_req = (state == S_DISPATCH);
  assign bus.running    = (state == S_RUN);
  assign bus.idle       = (state == S_SELECT) && !sel_found;

  // Lowest-index free slot; computed from the pre-edge valid vector so an
  // exiting slot cannot be handed to a load in the same cycle.
  always_comb begin
    free_idx = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = i[PW-1:0];
    end
  end

  // Scan offsets NPROC..1 so the smallest offset from cur_pid+1 wins; offset
  // NPROC wraps to cur_pid itself, letting a lone valid slot be reselected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = bus.cur_pid;
    cand      = '0;
    for (int i = NPROC; i >= 1; i--) begin
      cand = bus.cur_pid + i[PW-1:0];
      if (valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_WAIT;
      valid          <= '0;
      qcnt           <= '0;
      bus.cur_pid    <= PW'(NPROC - 1);
      bus.next_pc    <= '0;
      bus.page_base  <= '0;
      bus.page_limit <= '0;
      bus.load_err   <= 1'b0;
      for (int i = 0; i < NPROC; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      bus.load_err <= load_fire && load_bad;

      if (!bus.enable && (state != S_WAIT)) begin
        state <= S_WAIT;
      end else begin
        case (state)
          S_WAIT: begin
            if (bus.enable) state <= S_SELECT;
          end
          S_SELECT: begin
            if (sel_found) begin
              bus.cur_pid    <= sel_idx;
              bus.next_pc    <= pc_q[sel_idx];
              bus.page_base  <= base_q[sel_idx];
              bus.page_limit <= limit_q[sel_idx];
              state          <= S_DISPATCH;
            end
          end
          S_DISPATCH: begin
            if (bus.switch_ack) begin
              qcnt  <= QW'(QUANTUM - 1);
              state <= S_RUN;
            end
          end
          S_RUN: begin
            if (qcnt != '0) qcnt <= qcnt - QW'(1);
            if (bus.proc_exit) begin
              valid[bus.cur_pid] <= 1'b0;
              state              <= S_SELECT;
            end else if (bus.yield_req || (qcnt == '0)) begin
              state <= S_SAVE;
            end
          end
          S_SAVE: begin
            pc_q[bus.cur_pid] <= bus.pc_save;
            state             <= S_SELECT;
          end
          default: state <= S_WAIT;
        endcase
      end

      // The free slot is never the running one, so this cannot collide with
      // the SAVE write or the exit clear above.
      if (load_fire && !load_bad) begin
        valid[free_idx]   <= 1'b1;
        base_q[free_idx]  <= bus.load_page[31:16];
        limit_q[free_idx] <= bus.load_page[15:0];
        pc_q[free_idx]    <= {16'b0, bus.load_page[31:16]};
      end
    end
  end
endmodule
